s_axi_mem: RTL
==============

S_AXI_MEM -- requirements
Module: s_axi_mem
Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of data buses (8..1024, power of two).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, bit width of address buses.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, storage depth in DATA_WIDTH words (power of two).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h40000000, byte address of word 0.
REQ-005 SHALL have port s_axi_aclk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port s_axi_areset  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address.
REQ-008 SHALL have port s_axi_awlen  in  8  write beats minus one.
REQ-009 SHALL have port s_axi_awvalid  in  1  write address valid.
REQ-010 SHALL have port s_axi_awready  out  1  write address accepted.
REQ-011 SHALL have port s_axi_wdata  in  DATA_WIDTH  write beat data.
REQ-012 SHALL have port s_axi_wstrb  in  DATA_WIDTH/8  byte enables.
REQ-013 SHALL have port s_axi_wlast  in  1  last write beat marker.
REQ-014 SHALL have port s_axi_wvalid  in  1  write data valid.
REQ-015 SHALL have port s_axi_wready  out  1  write data accepted.
REQ-016 SHALL have port s_axi_bresp  out  2  write response.
REQ-017 SHALL have port s_axi_bvalid  out  1  write response valid.
REQ-018 SHALL have port s_axi_bready  in  1  write response accepted.
REQ-019 SHALL have port s_axi_araddr  in  ADDR_WIDTH  read burst start byte address.
REQ-020 SHALL have port s_axi_arlen  in  8  read beats minus one.
REQ-021 SHALL have port s_axi_arvalid  in  1  read address valid.
REQ-022 SHALL have port s_axi_arready  out  1  read address accepted.
REQ-023 SHALL have port s_axi_rdata  out  DATA_WIDTH  read beat data.
REQ-024 SHALL have port s_axi_rresp  out  2  read response.
REQ-025 SHALL have port s_axi_rlast  out  1  last read beat marker.
REQ-026 SHALL have port s_axi_rvalid  out  1  read data valid.
REQ-027 SHALL have port s_axi_rready  in  1  read data accepted.
Function
REQ-028 SHALL implement the downstream AXI4 slave for INCR, full-width bursts. Size, burst type, ID, lock, cache, prot, qos and user SHALL NOT be ported and SHALL be treated as INCR / full width.
REQ-029 SHALL compute word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8) and SHALL increment it by 1 per beat.
REQ-030 Write FSM states SHALL be W_IDLE, W_DATA and W_RESP, behaving as follows:
- W_IDLE: awready=1. An AW handshake latches index and awlen, then moves to W_DATA.
- W_DATA: wready=1. Each W handshake writes the bytes whose wstrb bit is set.
- Beat count awlen+1 SHALL end the burst and move to W_RESP; wlast SHALL be ignored.
- W_RESP: bvalid=1, held until bready, then returns to W_IDLE.
REQ-031 Read FSM states SHALL be R_IDLE and R_DATA, behaving as follows:
- R_IDLE: arready=1. An AR handshake moves to R_DATA with rvalid=1 on the next cycle.
- R_DATA: rdata, rresp and rlast SHALL be registered and held stable while rvalid=1 and rready=0.
- Throughput SHALL be 1 beat/cycle when rready=1.
- rlast=1 SHALL mark beat arlen; its handshake returns the FSM to R_IDLE.
REQ-032 Read and write channels SHALL operate concurrently. A same-cycle write and read of one word SHALL return the old data.
REQ-033 Bursts crossing 4KB boundaries SHALL NOT be checked. awlen/arlen up to 255 SHALL be supported.
Reset
REQ-034 While s_axi_areset=1, all ready/valid outputs, rlast and both resp outputs SHALL be 0, rdata SHALL be 0, both FSMs SHALL be IDLE, and memory contents SHALL NOT be cleared.
REQ-035 awready/arready SHALL rise on the first clock after reset release. Reset mid-burst SHALL abandon that burst with no further beats or responses.
Configuration
REQ-036 With S_AXI_MEM_ERR_EN defined, beats with index >= MEM_WORDS (or below BASE_ADDR) SHALL behave as follows:
- Writes are suppressed and bresp=2'b10 for that burst.
- Reads return rdata=0 and rresp=2'b10 for that beat.
REQ-037 Without S_AXI_MEM_ERR_EN, index SHALL wrap modulo MEM_WORDS and every response SHALL be 2'b00.
Verification
REQ-038 AW 0x40000000 len 15, wdata 0..15, wstrb 4'hF, then AR same -> bresp 00; rdata 0..15 in order; rlast only on beat 16.
REQ-039 Word holds 0xAAAAAAAA; write 0x12345678 with wstrb 4'b0011 -> readback 0xAAAA5678.
REQ-040 rready toggled every cycle over a 16-beat read -> rdata/rlast stable during stalls; 16 beats, no loss or duplication.
REQ-041 AW 0x40000FF8 len 3 -> with macro: words 1022/1023 written, bresp 10; without macro: wraps to words 0/1, bresp 00.
REQ-042 bready low for 10 cycles after last beat -> bvalid held, awready 0 until B handshake.
REQ-043 areset pulsed at read beat 5 -> rvalid 0 immediately; arready 1 one cycle after release; prior writes still readable.

Source files
------------

// File: rtl/s_axi_mem.sv
// s_axi_mem: AXI4 INCR burst slave backed by an internal word array.
// Define S_AXI_MEM_ERR_EN to answer out-of-range beats with SLVERR instead of wrapping.
module s_axi_mem #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           MEM_WORDS  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h40000000)
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_areset,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
`ifdef S_AXI_MEM_ERR_EN
   // Extra MSB marks an address below BASE_ADDR so it always compares out of range
   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
`else
   localparam int unsigned CNT_W  = IDX_W;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA} r_state_e;

   w_state_e              w_state;
   r_state_e              r_state;
   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
   logic [CNT_W-1:0]      w_idx_q, r_idx_q, aw_idx, ar_idx, r_next_idx;
   logic [7:0]            w_cnt_q, r_cnt_q;
   logic                  w_err_q, w_oob, w_fire, r_next_oob;
   logic [DATA_WIDTH-1:0] r_next_data;
   logic                  unused_wlast;

   // Burst length comes from awlen alone
   assign unused_wlast = s_axi_wlast;

`ifdef S_AXI_MEM_ERR_EN
   assign aw_idx     = {s_axi_awaddr < BASE_ADDR, ADDR_WIDTH'((s_axi_awaddr - BASE_ADDR) >> OFF_W)};
   assign ar_idx     = {s_axi_araddr < BASE_ADDR, ADDR_WIDTH'((s_axi_araddr - BASE_ADDR) >> OFF_W)};
   assign w_oob      = (w_idx_q >= CNT_W'(MEM_WORDS));
   assign r_next_oob = (r_next_idx >= CNT_W'(MEM_WORDS));
`else
   assign aw_idx     = CNT_W'((s_axi_awaddr - BASE_ADDR) >> OFF_W);
   assign ar_idx     = CNT_W'((s_axi_araddr - BASE_ADDR) >> OFF_W);
   assign w_oob      = 1'b0;
   assign r_next_oob = 1'b0;
`endif

   assign w_fire = (w_state == W_DATA) && s_axi_wvalid && s_axi_wready;

   always_comb begin
      r_next_idx  = (r_state == R_IDLE) ? ar_idx : r_idx_q + CNT_W'(1);
      r_next_data = r_next_oob ? '0 : mem[r_next_idx[IDX_W-1:0]];
   end

   // Storage is never reset; reads sample before same-edge writes land
   always_ff @(posedge s_axi_aclk) begin
      if (w_fire && !w_oob) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) mem[w_idx_q[IDX_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= 2'b00;
         w_idx_q       <= '0;
         w_cnt_q       <= '0;
         w_err_q       <= 1'b0;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               s_axi_awready <= 1'b1;
               if (s_axi_awready && s_axi_awvalid) begin
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  w_idx_q       <= aw_idx;
                  w_cnt_q       <= s_axi_awlen;
                  w_err_q       <= 1'b0;
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_idx_q <= w_idx_q + CNT_W'(1);
                  w_cnt_q <= w_cnt_q - 8'd1;
                  w_err_q <= w_err_q | w_oob;
                  if (w_cnt_q == 8'd0) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bresp  <= (w_err_q || w_oob) ? 2'b10 : 2'b00;
                     w_state      <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_bresp   <= 2'b00;
                  s_axi_awready <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rresp   <= 2'b00;
         s_axi_rdata   <= '0;
         r_idx_q       <= '0;
         r_cnt_q       <= '0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               s_axi_arready <= 1'b1;
               if (s_axi_arready && s_axi_arvalid) begin
                  s_axi_arready <= 1'b0;
                  s_axi_rvalid  <= 1'b1;
                  s_axi_rdata   <= r_next_data;
                  s_axi_rresp   <= r_next_oob ? 2'b10 : 2'b00;
                  s_axi_rlast   <= (s_axi_arlen == 8'd0);
                  r_idx_q       <= r_next_idx;
                  r_cnt_q       <= s_axi_arlen;
                  r_state       <= R_DATA;
               end
            end
            R_DATA: begin
               if (s_axi_rready) begin
                  if (s_axi_rlast) begin
                     s_axi_rvalid  <= 1'b0;
                     s_axi_rlast   <= 1'b0;
                     s_axi_rresp   <= 2'b00;
                     s_axi_arready <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     // r_cnt_q counts beats remaining after the one on the bus
                     s_axi_rdata <= r_next_data;
                     s_axi_rresp <= r_next_oob ? 2'b10 : 2'b00;
                     s_axi_rlast <= (r_cnt_q == 8'd1);
                     r_idx_q     <= r_next_idx;
                     r_cnt_q     <= r_cnt_q - 8'd1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule
